// File: rtl/edge_filter_bank_pkg.sv
// Shared definitions for the edge filter bank: counter sizing, reset-level
// validation and edge-type encoding for downstream consumers.
package edge_filter_bank_pkg;

    typedef enum logic {
        EDGE_FALL = 1'b0,
        EDGE_RISE = 1'b1
    } edge_type_e;

    // Filter counter must hold 0..len-1; never narrower than one bit.
    function automatic int cnt_width(input int len);
        return (len > 2) ? $clog2(len) : 1;
    endfunction

    function automatic bit rst_level_ok(input int lvl);
        return (lvl == 0) || (lvl == 1);
    endfunction

endpackage

// File: rtl/edge_filter_bank_if.sv
// Bus bundle for the edge filter bank: raw inputs, flag controls and
// conditioned outputs. master drives the inputs, slave is the filter bank.
interface edge_filter_bank_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sig_i;
    logic [WIDTH-1:0] clr_rise_i;
    logic [WIDTH-1:0] clr_fall_i;
    logic [WIDTH-1:0] irq_en_rise_i;
    logic [WIDTH-1:0] irq_en_fall_i;
    logic [WIDTH-1:0] level_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic [WIDTH-1:0] evt_rise_o;
    logic [WIDTH-1:0] evt_fall_o;
    logic [WIDTH-1:0] overrun_o;
    logic             irq_o;

    modport master (
        output sig_i, clr_rise_i, clr_fall_i, irq_en_rise_i, irq_en_fall_i,
        input  level_o, rise_o, fall_o, evt_rise_o, evt_fall_o, overrun_o, irq_o
    );

    modport slave (
        input  sig_i, clr_rise_i, clr_fall_i, irq_en_rise_i, irq_en_fall_i,
        output level_o, rise_o, fall_o, evt_rise_o, evt_fall_o, overrun_o, irq_o
    );
endinterface

// File: rtl/edge_filter_chan.sv
// One input channel: synchroniser, hold-time glitch filter, registered edge
// pulses, sticky rise/fall flags and an overrun flag.
module edge_filter_chan
    import edge_filter_bank_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 4,
    parameter logic RST_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    input  logic clr_rise_i,
    input  logic clr_fall_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic evt_rise_o,
    output logic evt_fall_o,
    output logic overrun_o
);
    localparam int            CW       = cnt_width(FILTER_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_evt_rise;
    logic                   r_evt_fall;
    logic                   r_overrun;
    logic                   w_s;
    logic                   w_accept;
    logic                   w_ovr_set;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_accept = (w_s != r_level) && (r_cnt == CNT_LAST);

    // An edge overruns only if its flag is still pending and not being cleared now.
    assign w_ovr_set = (r_rise & r_evt_rise & ~clr_rise_i) |
                       (r_fall & r_evt_fall & ~clr_fall_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync     <= {SYNC_STAGES{RST_LEVEL}};
            r_cnt      <= '0;
            r_level    <= RST_LEVEL;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_evt_rise <= 1'b0;
            r_evt_fall <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_i};
            r_rise <= w_accept & w_s;
            r_fall <= w_accept & ~w_s;

            if (w_s == r_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= w_s;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            r_evt_rise <= r_rise | (r_evt_rise & ~clr_rise_i);
            r_evt_fall <= r_fall | (r_evt_fall & ~clr_fall_i);
            r_overrun  <= w_ovr_set | (r_overrun & ~(clr_rise_i & clr_fall_i));
        end
    end

    assign level_o    = r_level;
    assign rise_o     = r_rise;
    assign fall_o     = r_fall;
    assign evt_rise_o = r_evt_rise;
    assign evt_fall_o = r_evt_fall;
    assign overrun_o  = r_overrun;

endmodule

// File: rtl/edge_filter_bank.sv
// Multi-channel input conditioner: WIDTH independent filter channels plus a
// maskable interrupt formed from their sticky flags.
module edge_filter_bank
    import edge_filter_bank_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int RST_LEVEL   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    edge_filter_bank_if.slave        bus
);
    // Out-of-range reset levels fall back to 0.
    localparam logic RST_BIT = (rst_level_ok(RST_LEVEL) && (RST_LEVEL == 1)) ? 1'b1 : 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            edge_filter_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILTER_LEN  (FILTER_LEN),
                .RST_LEVEL   (RST_BIT)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .sig_i      (bus.sig_i[gi]),
                .clr_rise_i (bus.clr_rise_i[gi]),
                .clr_fall_i (bus.clr_fall_i[gi]),
                .level_o    (bus.level_o[gi]),
                .rise_o     (bus.rise_o[gi]),
                .fall_o     (bus.fall_o[gi]),
                .evt_rise_o (bus.evt_rise_o[gi]),
                .evt_fall_o (bus.evt_fall_o[gi]),
                .overrun_o  (bus.overrun_o[gi])
            );
        end
    endgenerate

    assign bus.irq_o = |((bus.evt_rise_o & bus.irq_en_rise_i) |
                         (bus.evt_fall_o & bus.irq_en_fall_i));

endmodule

// File: tb/tb_edge_filter_bank.sv
// Directed bench for edge_filter_bank (WIDTH=4, SYNC_STAGES=2, FILTER_LEN=4):
// inputs change just after the falling edge, outputs are checked there too.
module tb_edge_filter_bank;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    edge_filter_bank_if #(.WIDTH(4)) bus ();

    edge_filter_bank #(
        .WIDTH       (4),
        .SYNC_STAGES (2),
        .FILTER_LEN  (4),
        .RST_LEVEL   (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Drive ch3 to val and wait for the matching pulse; optionally strobe the
    // matching clear in the pulse cycle. Returns after one more cycle.
    task automatic edge3(input logic val, input logic clr_coincide, output int lat);
        lat = -1;
        bus.sig_i[3] = val;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if ((val && bus.rise_o[3]) || (!val && bus.fall_o[3])) begin
                lat = k;
                if (clr_coincide) begin
                    if (val) bus.clr_rise_i[3] = 1'b1;
                    else     bus.clr_fall_i[3] = 1'b1;
                end
                break;
            end
        end
        @(negedge clk);
        bus.clr_rise_i[3] = 1'b0;
        bus.clr_fall_i[3] = 1'b0;
    endtask

    task automatic test_reset();
        logic [24:0] obs;
        bus.sig_i = '0; bus.clr_rise_i = '0; bus.clr_fall_i = '0;
        bus.irq_en_rise_i = '0; bus.irq_en_fall_i = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        obs = {bus.level_o, bus.rise_o, bus.fall_o, bus.evt_rise_o, bus.evt_fall_o, bus.overrun_o, bus.irq_o};
        total++;
        if (obs !== 25'd0) begin
            bad++; $display("FAIL reset_state: got %h expected 0", obs);
        end
        rst = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            obs = {bus.level_o, bus.rise_o, bus.fall_o, bus.evt_rise_o, bus.evt_fall_o, bus.overrun_o, bus.irq_o};
            total++;
            if (obs !== 25'd0) begin
                bad++; $display("FAIL idle_cycle%0d: got %h expected 0", k, obs);
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_clean_rise();
        bus.irq_en_rise_i = 4'b0001;
        bus.sig_i[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 5) begin
                total++;
                if ({bus.level_o[0], bus.rise_o[0]} !== 2'b00) begin
                    bad++; $display("FAIL rise_early: level/rise=%b expected 00", {bus.level_o[0], bus.rise_o[0]});
                end
            end
            if (k == 6) begin
                total++;
                if ({bus.level_o[0], bus.rise_o[0], bus.irq_o} !== 3'b110) begin
                    bad++; $display("FAIL rise_at6: level/rise/irq=%b expected 110", {bus.level_o[0], bus.rise_o[0], bus.irq_o});
                end
            end
            if (k == 7) begin
                total++;
                if ({bus.rise_o[0], bus.evt_rise_o[0], bus.irq_o, bus.fall_o[0]} !== 4'b0110) begin
                    bad++; $display("FAIL rise_after: rise/evt/irq/fall=%b expected 0110",
                                    {bus.rise_o[0], bus.evt_rise_o[0], bus.irq_o, bus.fall_o[0]});
                end
            end
        end
        bus.clr_rise_i[0] = 1'b1;
        @(negedge clk);
        bus.clr_rise_i[0] = 1'b0;
        total++;
        if ({bus.evt_rise_o[0], bus.irq_o} !== 2'b00) begin
            bad++; $display("FAIL rise_clear: evt/irq=%b expected 00", {bus.evt_rise_o[0], bus.irq_o});
        end
        $display("test_clean_rise: done");
    endtask

    task automatic test_glitch();
        int nrise = 0, nfall = 0, rise_at = -1, fall_at = -1;
        bus.sig_i[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.rise_o[1] || bus.level_o[1]) nrise++;
            if (k == 3) bus.sig_i[1] = 1'b0;
        end
        total++;
        if (nrise !== 0) begin
            bad++; $display("FAIL glitch3: saw %0d high level/pulse cycles expected 0", nrise);
        end
        nrise = 0;
        bus.sig_i[1] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (bus.rise_o[1]) begin nrise++; rise_at = k; end
            if (bus.fall_o[1]) begin nfall++; fall_at = k; end
            if (k == 4) bus.sig_i[1] = 1'b0;
        end
        total++;
        if ({nrise, rise_at, nfall, fall_at} !== {32'd1, 32'd6, 32'd1, 32'd10}) begin
            bad++; $display("FAIL glitch4: rises=%0d at %0d falls=%0d at %0d expected 1 at 6, 1 at 10",
                            nrise, rise_at, nfall, fall_at);
        end
        $display("test_glitch: done");
    endtask

    task automatic test_bounce();
        logic [7:0] pat = 8'b1111_0111;
        int nrise = 0, rise_at = -1;
        bus.sig_i[2] = pat[0];
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (bus.rise_o[2]) begin nrise++; rise_at = k; end
            if (k < 8) bus.sig_i[2] = pat[k];
        end
        total++;
        if ({nrise, rise_at} !== {32'd1, 32'd10} || bus.level_o[2] !== 1'b1) begin
            bad++; $display("FAIL bounce: rises=%0d at %0d level=%b expected 1 at 10 level 1",
                            nrise, rise_at, bus.level_o[2]);
        end
        $display("test_bounce: done");
    endtask

    task automatic test_overrun();
        int lat;
        edge3(1'b1, 1'b0, lat);
        edge3(1'b0, 1'b0, lat);
        edge3(1'b1, 1'b0, lat);
        total++;
        if ({lat, 29'd0, bus.overrun_o[3], bus.evt_rise_o[3], bus.evt_fall_o[3]} !== {32'd6, 32'b111}) begin
            bad++; $display("FAIL ovr_set: lat=%0d ovr/evtr/evtf=%b expected 6 111",
                            lat, {bus.overrun_o[3], bus.evt_rise_o[3], bus.evt_fall_o[3]});
        end
        bus.clr_rise_i[3] = 1'b1;
        bus.clr_fall_i[3] = 1'b1;
        @(negedge clk);
        bus.clr_rise_i[3] = 1'b0;
        bus.clr_fall_i[3] = 1'b0;
        total++;
        if ({bus.overrun_o[3], bus.evt_rise_o[3], bus.evt_fall_o[3]} !== 3'b000) begin
            bad++; $display("FAIL ovr_clear: ovr/evtr/evtf=%b expected 000",
                            {bus.overrun_o[3], bus.evt_rise_o[3], bus.evt_fall_o[3]});
        end
        edge3(1'b0, 1'b0, lat);
        edge3(1'b1, 1'b0, lat);
        total++;
        if ({bus.overrun_o[3], bus.evt_rise_o[3], bus.evt_fall_o[3]} !== 3'b011) begin
            bad++; $display("FAIL ovr_fresh: ovr/evtr/evtf=%b expected 011",
                            {bus.overrun_o[3], bus.evt_rise_o[3], bus.evt_fall_o[3]});
        end
        edge3(1'b0, 1'b1, lat);
        edge3(1'b1, 1'b1, lat);
        total++;
        if ({lat, 29'd0, bus.overrun_o[3], bus.evt_rise_o[3], bus.evt_fall_o[3]} !== {32'd6, 32'b011}) begin
            bad++; $display("FAIL set_wins: lat=%0d ovr/evtr/evtf=%b expected 6 011",
                            lat, {bus.overrun_o[3], bus.evt_rise_o[3], bus.evt_fall_o[3]});
        end
        $display("test_overrun: done");
    endtask

    task automatic test_multi();
        logic [3:0] seen_r = '0, seen_f = '0;
        bus.sig_i[1] = 1'b1;
        bus.sig_i[2] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 6) begin seen_r = bus.rise_o; seen_f = bus.fall_o; end
        end
        total++;
        if ({seen_r, seen_f} !== 8'b0010_0100) begin
            bad++; $display("FAIL multi: rise=%b fall=%b expected 0010 0100", seen_r, seen_f);
        end
        $display("test_multi: done");
    endtask

    task automatic test_reset_mid();
        logic [24:0] obs;
        int nrise = 0, rise_at = -1;
        bus.sig_i = '0;
        bus.irq_en_fall_i = 4'b1111;
        repeat (15) @(negedge clk);
        total++;
        if (bus.irq_o !== 1'b1) begin
            bad++; $display("FAIL pre_reset_irq: got %b expected 1", bus.irq_o);
        end
        bus.sig_i[0] = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        obs = {bus.level_o, bus.rise_o, bus.fall_o, bus.evt_rise_o, bus.evt_fall_o, bus.overrun_o, bus.irq_o};
        total++;
        if (obs !== 25'd0) begin
            bad++; $display("FAIL async_reset: got %h expected 0", obs);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.rise_o[0]) begin nrise++; rise_at = k; end
        end
        total++;
        if ({nrise, rise_at} !== {32'd1, 32'd6}) begin
            bad++; $display("FAIL reset_mid_rise: rises=%0d at %0d expected 1 at 6", nrise, rise_at);
        end
        $display("test_reset_mid: done");
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch();
        test_bounce();
        test_overrun();
        test_multi();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
